muldiv_hilo_sequencer: RTL and testbench
========================================

Name: muldiv_hilo_sequencer

Overview:
- Iterative multiply/divide controller that owns all writes to the register file's HI/LO pair.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-step shift-add or restoring-divide sequence.
- Issues a single-cycle HI/LO write strobe on completion.
- Raises a stall request to the hazard logic while a result is pending and a dependent instruction or a new mul/div wants to proceed.

Parameters:
- ITERATIONS, 32, number of RUN-state steps; equals operand width; not intended to change.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clk_enable  input  1  global advance enable; when low all state, counters and outputs hold.
- start  input  1  issue request for a mul/div op; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  32  rs value (multiplicand / dividend).
- operand_b  input  32  rt value (multiplier / divisor).
- hilo_read_request  input  1  decode/execute holds MFHI/MFLO.
- busy  output  1  operation in flight.
- stall_request  output  1  to hazard unit: busy & (hilo_read_request | start).
- hilo_write_enable  output  1  one-cycle HI/LO write strobe.
- hi_result  output  32  HI write data.
- lo_result  output  32  LO write data.

Behaviour:
- Clocking and reset:
  - All state changes on posedge clk, qualified by clk_enable.
  - Reset has priority over clk_enable.
  - Reset values: state IDLE, busy 0, stall_request 0, hilo_write_enable 0, hi_result 0, lo_result 0, step counter 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start & clk_enable at cycle T: latch op, operand magnitudes (signed ops take |x|; unsigned ops use raw values) and result-sign flags. Load counter = ITERATIONS-1. Go to RUN.
- RUN (cycles T+1..T+32), one step per enabled cycle:
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes.
  - Counter decrements each step; at 0 go to DONE.
- DONE (cycle T+33):
  - Apply sign correction and drive hi_result/lo_result.
  - hilo_write_enable = 1 for exactly this cycle; next state IDLE.
  - hi_result/lo_result hold their values until the next DONE or reset.
- busy = 1 in RUN and DONE (T+1..T+33); 0 in IDLE. Combinational decode of state.
- start while busy (including DONE): ignored, not queued. stall_request keeps the issuing instruction held; it is accepted on the first IDLE cycle.
- Latency: exactly 33 enabled cycles from accepting edge to write-strobe cycle; a dependent MFHI/MFLO proceeds at T+34.
- Signed result rules:
  - MULT: 64-bit product negated when operand signs differ.
  - DIV: quotient truncates toward zero and is negated when signs differ; remainder takes the dividend's sign.
  - LO = product[31:0] / quotient; HI = product[63:32] / remainder.
- Divisor zero (DIV or DIVU): full latency still taken; HI = operand_a, LO = 0xFFFFFFFF, no sign correction.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (falls out of magnitude arithmetic; must not trap).
- clk_enable low mid-operation: counter and state freeze; latency extends by the number of disabled cycles. hilo_write_enable stays high if frozen in DONE, but the register file sees only one enabled write.
- reset mid-operation: return to IDLE next edge; no write strobe for the aborted op.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at T -> busy T+1..T+33; hilo_write_enable only at T+33 with HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> LO=0x7FFFFFFC, HI=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 5 / 0 -> HI=0x00000005, LO=0xFFFFFFFF, still at T+33.
- hilo_read_request held from T+2 -> stall_request high T+2..T+33, low at T+34. A second start at T+5 held until IDLE -> accepted at T+34, its strobe at T+67.
- reset asserted at T+10 -> busy 0 from T+11, no hilo_write_enable within 40 following cycles. Outputs return to 0.
- clk_enable low for 5 cycles during RUN -> strobe moves to T+38 with correct results. A start pulse while clk_enable is low in IDLE is not accepted.

Source files
------------

// File: rtl/muldiv_hilo_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO write port.
// Works on operand magnitudes, one step per enabled cycle; signs are re-applied on entry to DONE.
module muldiv_hilo_sequencer #(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hilo_read_request,
    output logic        busy,
    output logic        stall_request,
    output logic        hilo_write_enable,
    output logic [31:0] hi_result,
    output logic [31:0] lo_result
);
    localparam int CW = $clog2(ITERATIONS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          is_div_q, is_div_d;
    logic          neg_main_q, neg_main_d;
    logic          neg_rem_q, neg_rem_d;
    logic [31:0]   acc_hi_q, acc_hi_d;
    logic [31:0]   acc_lo_q, acc_lo_d;
    logic [31:0]   opnd_q, opnd_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          is_signed, a_neg, b_neg;
    logic [31:0]   a_mag, b_mag;
    logic [32:0]   mul_sum, div_shift;
    logic          div_ge;
    logic [31:0]   step_hi, step_lo, quo_fix, rem_fix;
    logic [63:0]   prod, prod_fix;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        is_signed = ~op[0];
        a_neg     = is_signed & operand_a[31];
        b_neg     = is_signed & operand_b[31];
        a_mag     = a_neg ? (32'd0 - operand_a) : operand_a;
        b_mag     = b_neg ? (32'd0 - operand_b) : operand_b;

        // Multiply: {acc_hi, acc_lo} is the product/multiplier shift register.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
        div_shift = {acc_hi_q, acc_lo_q[31]};
        div_ge    = div_shift >= {1'b0, opnd_q};

        if (is_div_q) begin
            step_hi = div_ge ? (div_shift[31:0] - opnd_q) : div_shift[31:0];
            step_lo = {acc_lo_q[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], acc_lo_q[31:1]};
        end

        prod     = {step_hi, step_lo};
        prod_fix = neg_main_q ? (64'd0 - prod) : prod;
        quo_fix  = neg_main_q ? (32'd0 - step_lo) : step_lo;
        // With a zero divisor the remainder path ends holding |a|, so the dividend-sign fix restores raw a.
        rem_fix  = neg_rem_q ? (32'd0 - step_hi) : step_hi;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    count_d    = CW'(ITERATIONS - 1);
                    is_div_d   = op[1];
                    neg_main_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    acc_hi_d   = 32'd0;
                    acc_lo_d   = op[1] ? a_mag : b_mag;
                    opnd_d     = op[1] ? b_mag : a_mag;
                end
            end
            RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        lo_d = (opnd_q == 32'd0) ? step_lo : quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
            opnd_q     <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else if (clk_enable) begin
            state_q    <= state_d;
            count_q    <= count_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy              = (state_q != IDLE);
    assign hilo_write_enable = (state_q == DONE);
    assign stall_request     = busy & (hilo_read_request | start);
    assign hi_result         = hi_q;
    assign lo_result         = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Self-checking bench: arithmetic reference results plus a latency model, compared every cycle.
module tb_muldiv_hilo_sequencer;
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset, clk_enable, start, hilo_read_request;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        busy, stall_request, hilo_write_enable;
    logic [31:0] hi_result, lo_result;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_on  = 1'b0;

    int          m_cnt = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    muldiv_hilo_sequencer #(.ITERATIONS(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_enable        (clk_enable),
        .start             (start),
        .op                (op),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .hilo_read_request (hilo_read_request),
        .busy              (busy),
        .stall_request     (stall_request),
        .hilo_write_enable (hilo_write_enable),
        .hi_result         (hi_result),
        .lo_result         (lo_result)
    );

    always #5 clk = ~clk;

    // Returns {HI, LO} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = ua * ub;
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Latency model: counts enabled cycles since acceptance; strobe cycle is the 33rd.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (clk_enable) begin
            if (m_cnt == 0) begin
                if (start) begin
                    m_cnt <= 1;
                    m_res <= ref_result(op, operand_a, operand_b);
                end
            end else if (m_cnt == LAT) begin
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == LAT - 1) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 64'(busy), 64'(m_cnt != 0));
            chk("hilo_write_enable", 64'(hilo_write_enable), 64'(m_cnt == LAT));
            chk("stall_request", 64'(stall_request), 64'((m_cnt != 0) && (hilo_read_request || start)));
            chk("hi_result", 64'(hi_result), 64'(m_hi));
            chk("lo_result", 64'(lo_result), 64'(m_lo));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int t0);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        t0        = cyc;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_strobe(input string name, input int t0, input int exp_off,
                               input logic [31:0] eh, input logic [31:0] el);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            if (hilo_write_enable) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, " strobe seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({name, " latency"}, 64'(cyc - t0), 64'(exp_off));
            chk({name, " hi"}, 64'(hi_result), 64'(eh));
            chk({name, " lo"}, 64'(lo_result), 64'(el));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n_we;
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; hilo_read_request = 1'b0;
        op = 2'd0; operand_a = '0; operand_b = '0;

        chk("model MULTU", ref_result(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model MULT", ref_result(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model DIV", ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model DIVU", ref_result(2'd3, 32'hFFFF_FFF9, 32'd2), 64'h0000_0001_7FFF_FFFC);
        chk("model DIV ovf", ref_result(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("model DIVU0", ref_result(2'd3, 32'd5, 32'd0), 64'h0000_0005_FFFF_FFFF);

        tick(2);
        reset  = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset we", 64'(hilo_write_enable), 64'd0);
        chk("reset hi", 64'(hi_result), 64'd0);
        chk("reset lo", 64'(lo_result), 64'd0);
        tick(1);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
        wait_strobe("MULTU max", t0, 33, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, t0);
        wait_strobe("MULT -3*5", t0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, t0);
        wait_strobe("DIV -7/2", t0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, t0);
        wait_strobe("DIVU", t0, 33, 32'h0000_0001, 32'h7FFF_FFFC);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        wait_strobe("DIV ovf", t0, 33, 32'h0000_0000, 32'h8000_0000);
        issue(2'd3, 32'd5, 32'd0, t0);
        wait_strobe("DIVU by 0", t0, 33, 32'h0000_0005, 32'hFFFF_FFFF);

        // Read stall from T+2 and a second start held from T+5 until the first IDLE cycle.
        issue(2'd3, 32'd100, 32'd7, t0);
        tick(1);
        hilo_read_request = 1'b1;
        tick(3);
        op = 2'd0; operand_a = 32'hFFFF_FFFE; operand_b = 32'd3; start = 1'b1;
        tick(28);
        @(negedge clk);
        chk("stall at T+33", 64'(stall_request), 64'd1);
        tick(1);
        hilo_read_request = 1'b0;
        @(negedge clk);
        chk("stall at T+34", 64'(stall_request), 64'd0);
        tick(1);
        start = 1'b0;
        wait_strobe("held start", t0, 67, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(2'd1, 32'd1234, 32'd5678, t0);
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi_result), 64'd0);
        chk("abort lo", 64'(lo_result), 64'd0);
        n_we = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_write_enable) n_we++;
        end
        chk("abort no strobe", 64'(n_we), 64'd0);
        tick(1);

        issue(2'd2, 32'hFFFF_FFF9, 32'd2, t0);
        tick(9);
        clk_enable = 1'b0;
        tick(5);
        clk_enable = 1'b1;
        wait_strobe("enable gap", t0, 38, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        clk_enable = 1'b0;
        op = 2'd1; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        clk_enable = 1'b1;
        @(negedge clk);
        chk("disabled start ignored", 64'(busy), 64'd0);
        tick(1);

        for (int i = 0; i < 5000; i++) begin
            reset             = ($urandom_range(0, 599) == 0);
            clk_enable        = ($urandom_range(0, 9) != 0);
            start             = ($urandom_range(0, 5) == 0);
            op                = 2'($urandom_range(0, 3));
            operand_a         = pick();
            operand_b         = pick();
            hilo_read_request = ($urandom_range(0, 3) == 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
